// File: rtl/grant_pkg.sv
// Shared types and helpers for the arbiter / grant-lock path.
package grant_pkg;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

    localparam int N_REQ = 4;

    // Keeps only the highest set bit (bit N_REQ-1 has top priority).
    function automatic logic [N_REQ-1:0] onehot_msb(input logic [N_REQ-1:0] vec);
        logic [N_REQ-1:0] res;
        res = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (vec[i]) begin
                res    = '0;
                res[i] = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic is_onehot(input logic [N_REQ-1:0] vec);
        return (vec != '0) && ((vec & (vec - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/onehot_mux.sv
// One-hot AND-OR select of per-requester data and last slices; all-zero select yields zero.
module onehot_mux #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic [N-1:0]   sel_i,
    input  logic [N*W-1:0] data_i,
    input  logic [N-1:0]   last_i,
    output logic [W-1:0]   data_o,
    output logic           last_o
);

    always_comb begin
        data_o = '0;
        last_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel_i[i]) begin
                data_o = data_o | data_i[i*W +: W];
                last_o = last_o | last_i[i];
            end
        end
    end

endmodule

// File: rtl/grant_lock.sv
// Locks the shared output channel to the granted requester for a whole transfer.
// One-cycle grant-to-valid latency; holds the beat while out_ready is low.
module grant_lock
    import grant_pkg::*;
#(
    parameter int N         = N_REQ,
    parameter int W         = 8,
    parameter int MAX_BEATS = 16,
    localparam int CW       = $clog2(MAX_BEATS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   grant,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   last,
    input  logic [N*W-1:0] data_in,
    input  logic           out_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    output logic [N-1:0]   owner,
    output logic           busy,
    output logic [CW-1:0]  beat_cnt,
    output logic           done,
    output logic           abort,
    output logic           err_grant
);

    state_e         state_q, state_d;
    logic [N-1:0]   owner_q, owner_d;
    logic [CW-1:0]  beat_cnt_q, beat_cnt_d;
    logic           done_q, done_d;
    logic           abort_q, abort_d;
    logic           err_grant_q, err_grant_d;

    logic [W-1:0]   mux_data;
    logic           mux_last;
    logic           owner_req;
    logic           cap_beat;
    logic           accept;

    onehot_mux #(.N(N), .W(W)) u_mux (
        .sel_i  (owner_q),
        .data_i (data_in),
        .last_i (last),
        .data_o (mux_data),
        .last_o (mux_last)
    );

    assign busy      = (state_q == LOCKED);
    assign owner_req = |(req & owner_q);
    assign cap_beat  = (beat_cnt_q == CW'(MAX_BEATS - 1));
    assign out_valid = busy & owner_req;
    assign out_data  = busy ? mux_data : '0;
    assign out_last  = busy & (mux_last | cap_beat);
    assign accept    = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        beat_cnt_d  = beat_cnt_q;
        done_d      = 1'b0;
        abort_d     = 1'b0;
        err_grant_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant != '0) begin
                    state_d     = LOCKED;
                    owner_d     = onehot_msb(grant);
                    beat_cnt_d  = '0;
                    err_grant_d = !is_onehot(grant);
                end
            end
            LOCKED: begin
                // Owner withdrawing its request ends the transfer; no beat moves that cycle.
                if (!owner_req) begin
                    state_d    = IDLE;
                    owner_d    = '0;
                    beat_cnt_d = '0;
                    abort_d    = 1'b1;
                end else if (accept && out_last) begin
                    state_d    = IDLE;
                    owner_d    = '0;
                    beat_cnt_d = '0;
                    done_d     = 1'b1;
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            beat_cnt_q  <= '0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            err_grant_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            beat_cnt_q  <= beat_cnt_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            err_grant_q <= err_grant_d;
        end
    end

    assign owner     = owner_q;
    assign beat_cnt  = beat_cnt_q;
    assign done      = done_q;
    assign abort     = abort_q;
    assign err_grant = err_grant_q;

endmodule

// File: tb/tb_grant_lock.sv
// Scoreboard bench for grant_lock: expected beats queued as driven, compared on accept.
module tb_grant_lock;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 16;
    localparam int CW = $clog2(MB);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   grant = '0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   last = '0;
    logic [N*W-1:0] data_in = '0;
    logic           out_ready = 1'b0;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [N-1:0]   owner;
    logic           busy;
    logic [CW-1:0]  beat_cnt;
    logic           done;
    logic           abort;
    logic           err_grant;

    typedef struct packed {
        logic [W-1:0] dat;
        logic         lst;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    grant_lock #(.N(N), .W(W), .MAX_BEATS(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .grant     (grant),
        .req       (req),
        .last      (last),
        .data_in   (data_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .owner     (owner),
        .busy      (busy),
        .beat_cnt  (beat_cnt),
        .done      (done),
        .abort     (abort),
        .err_grant (err_grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one beat from requester idx, queue its expectation, advance one cycle.
    task automatic beat(input int idx, input logic [W-1:0] d, input logic lst);
        exp_t e;
        data_in[idx*W +: W] = d;
        last[idx]           = lst;
        e.dat = d;
        e.lst = lst;
        exp_q.push_back(e);
        cyc();
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_beat", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("beat_data", 32'(out_data), 32'(e.dat));
                chk("beat_last", 32'(out_last), 32'(e.lst));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) cyc();
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(beat_cnt), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_flags", 32'({done, abort, err_grant, out_last}), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        cyc();

        // Single transfer from requester 3
        grant = 4'b1000; req = 4'b1000;
        cyc();
        grant = '0;
        chk("t1_owner", 32'(owner), 32'b1000);
        chk("t1_busy", 32'(busy), 32'd1);
        beat(3, 8'h11, 1'b0);
        beat(3, 8'h22, 1'b0);
        beat(3, 8'h33, 1'b1);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy_drop", 32'(busy), 32'd0);
        chk("t1_owner_clr", 32'(owner), 32'd0);
        req = '0; last = '0;
        cyc();
        chk("t1_done_pulse", 32'(done), 32'd0);

        // Backpressure on requester 0
        grant = 4'b0001; req = 4'b0001;
        cyc();
        grant = '0;
        beat(0, 8'hA1, 1'b0);
        beat(0, 8'hA2, 1'b0);
        begin
            exp_t e;
            data_in[0 +: W] = 8'hA3;
            e.dat = 8'hA3; e.lst = 1'b0;
            exp_q.push_back(e);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", 32'(out_data), 32'hA3);
            chk("bp_cnt", 32'(beat_cnt), 32'd2);
        end
        out_ready = 1'b1;
        cyc();
        chk("bp_resume_cnt", 32'(beat_cnt), 32'd3);
        beat(0, 8'hA4, 1'b1);
        chk("bp_done", 32'(done), 32'd1);
        req = '0; last = '0;
        cyc();

        // Grant changes while locked
        grant = 4'b0100; req = 4'b0110;
        cyc();
        grant = 4'b0010;
        chk("gc_owner0", 32'(owner), 32'b0100);
        beat(2, 8'h51, 1'b0);
        chk("gc_owner1", 32'(owner), 32'b0100);
        beat(2, 8'h52, 1'b1);
        chk("gc_idle_owner", 32'(owner), 32'd0);
        chk("gc_idle_busy", 32'(busy), 32'd0);
        last = '0;
        cyc();
        grant = '0;
        chk("gc_relock", 32'(owner), 32'b0010);
        beat(1, 8'h61, 1'b1);
        chk("gc_done", 32'(done), 32'd1);
        req = '0; last = '0;
        cyc();

        // Beat-count cap on requester 0, last never asserted
        grant = 4'b0001; req = 4'b0001;
        cyc();
        grant = '0;
        for (int i = 0; i < MB - 1; i++) beat(0, 8'(i), 1'b0);
        begin
            exp_t e;
            data_in[0 +: W] = 8'hF0;
            e.dat = 8'hF0; e.lst = 1'b1;
            exp_q.push_back(e);
        end
        #1;
        chk("cap_cnt", 32'(beat_cnt), 32'(MB - 1));
        chk("cap_last", 32'(out_last), 32'd1);
        cyc();
        chk("cap_done", 32'(done), 32'd1);
        chk("cap_abort", 32'(abort), 32'd0);
        chk("cap_busy", 32'(busy), 32'd0);
        req = '0;
        cyc();

        // Abort after two beats
        grant = 4'b1000; req = 4'b1000;
        cyc();
        grant = '0;
        beat(3, 8'h71, 1'b0);
        beat(3, 8'h72, 1'b0);
        req = '0;
        cyc();
        chk("ab_abort", 32'(abort), 32'd1);
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_owner", 32'(owner), 32'd0);
        chk("ab_cnt", 32'(beat_cnt), 32'd0);
        cyc();
        chk("ab_pulse", 32'(abort), 32'd0);

        // Multi-hot grant
        grant = 4'b0110; req = 4'b0100;
        cyc();
        grant = '0;
        chk("mh_owner", 32'(owner), 32'b0100);
        chk("mh_err", 32'(err_grant), 32'd1);
        beat(2, 8'h81, 1'b1);
        chk("mh_err_pulse", 32'(err_grant), 32'd0);
        chk("mh_done", 32'(done), 32'd1);
        req = '0; last = '0;
        cyc();

        // Reset mid-transfer after five beats
        grant = 4'b0010; req = 4'b0010;
        cyc();
        grant = '0;
        for (int i = 0; i < 5; i++) beat(1, 8'(8'hC0 + i), 1'b0);
        chk("mr_cnt", 32'(beat_cnt), 32'd5);
        rst = 1'b1;
        #1;
        chk("mr_owner", 32'(owner), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_cnt0", 32'(beat_cnt), 32'd0);
        chk("mr_out", 32'({out_valid, out_last, out_data}), 32'd0);
        cyc();
        chk("mr_no_pulse", 32'({done, abort}), 32'd0);
        rst = 1'b0; req = '0;
        cyc();
        chk("mr_after_pulse", 32'({done, abort}), 32'd0);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
